// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller and its SRAM wait FSM.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int REG_W_DEF       = 4;
    localparam int WAIT_CYCLES_DEF = 4;
    localparam int WCNT_W          = 4;
    localparam int STALL_W         = 16;

endpackage

// File: rtl/mem_wait_fsm.sv
// SRAM wait-state sequencer: tracks one memory access and freezes the pipe until DONE.
//  state | meaning
//  IDLE  | no access in flight; a memory instruction in MEM starts one
//  WAIT  | SRAM access in progress, wcnt counts down to terminal count 0
//  DONE  | data available; the instruction leaves MEM this cycle
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_access,
    output logic freeze,
    output logic sram_busy
);

    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_CYCLES - 2);

    mem_state_e        r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_sram_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wcnt      <= '0;
            r_sram_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_access) begin
                        r_state     <= ST_WAIT;
                        r_wcnt      <= WCNT_INIT;
                        r_sram_busy <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end else begin
                        r_state     <= ST_DONE;
                        r_sram_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_wcnt      <= '0;
                    r_sram_busy <= 1'b0;
                end
            endcase
        end
    end

    // Freeze must act in the same cycle the access appears, so it is not registered.
    assign freeze    = mem_access & (r_state != ST_DONE);
    assign sram_busy = r_sram_busy;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: hazard detection, freeze/branch/hazard priority mux and stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int REG_W       = REG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REG_W-1:0]   id_src1,
    input  logic [REG_W-1:0]   id_src2,
    input  logic               id_src1_vld,
    input  logic               id_src2_vld,
    input  logic [REG_W-1:0]   ex_dest,
    input  logic               ex_wb_en,
    input  logic               ex_mem_r_en,
    input  logic [REG_W-1:0]   mem_dest,
    input  logic               mem_wb_en,
    input  logic               fwd_en,
    input  logic               ex_branch_taken,
    input  logic               mem_access,
    output logic               pc_load,
    output logic               ifid_load,
    output logic               idex_load,
    output logic               exmem_load,
    output logic               memwb_load,
    output logic               ifid_clear,
    output logic               idex_clear,
    output logic               sram_busy,
    output logic [STALL_W-1:0] stall_cnt
);

    logic w_freeze;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_hazard;
    logic [STALL_W-1:0] r_stall_cnt;

    mem_wait_fsm #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_mem_wait_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_access(mem_access),
        .freeze    (w_freeze),
        .sram_busy (sram_busy)
    );

    assign w_ex_hit  = ex_wb_en & ((id_src1_vld & (id_src1 == ex_dest)) |
                                   (id_src2_vld & (id_src2 == ex_dest)));
    assign w_mem_hit = mem_wb_en & ((id_src1_vld & (id_src1 == mem_dest)) |
                                    (id_src2_vld & (id_src2 == mem_dest)));

    // With forwarding only a load in EX cannot be bypassed in time.
    assign w_hazard  = fwd_en ? (w_ex_hit & ex_mem_r_en) : (w_ex_hit | w_mem_hit);

    always_comb begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        idex_load  = 1'b1;
        exmem_load = 1'b1;
        memwb_load = 1'b1;
        ifid_clear = 1'b0;
        idex_clear = 1'b0;
        if (w_freeze) begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exmem_load = 1'b0;
            memwb_load = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
        end else if (w_hazard) begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((w_freeze | w_hazard) && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl against a cycle-phase reference model.
module tb_pipe_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
    logic id_src1_vld, id_src2_vld, ex_wb_en, ex_mem_r_en, mem_wb_en;
    logic fwd_en, ex_branch_taken, mem_access;
    logic pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic ifid_clear, idex_clear, sram_busy;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: position of the current memory instruction within its MEM residency, -1 = none.
    int          m_phase = -1;
    int          m_stall = 0;
    logic [6:0]  last_ctrl;

    always #5 clk = ~clk;

    pipe_ctrl #(.WAIT_CYCLES(W), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .fwd_en(fwd_en), .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
        .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
        .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_clear(ifid_clear), .idex_clear(idex_clear),
        .sram_busy(sram_busy), .stall_cnt(stall_cnt)
    );

    wire [6:0] w_ctrl = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                         ifid_clear, idex_clear};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        logic [3:0] src [2];
        bit         vld [2];
        bit         hz = 0;
        src[0] = id_src1; src[1] = id_src2;
        vld[0] = id_src1_vld; vld[1] = id_src2_vld;
        for (int i = 0; i < 2; i++) begin
            if (vld[i]) begin
                if (fwd_en) begin
                    if (ex_wb_en && ex_mem_r_en && src[i] == ex_dest) hz = 1;
                end else begin
                    if (ex_wb_en && src[i] == ex_dest) hz = 1;
                    if (mem_wb_en && src[i] == mem_dest) hz = 1;
                end
            end
        end
        return hz;
    endfunction

    task automatic clr_in();
        id_src1 = 0; id_src2 = 0; ex_dest = 0; mem_dest = 0;
        id_src1_vld = 0; id_src2_vld = 0; ex_wb_en = 0; ex_mem_r_en = 0; mem_wb_en = 0;
        fwd_en = 0; ex_branch_taken = 0; mem_access = 0;
    endtask

    task automatic rand_in();
        id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
        ex_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
        id_src1_vld = 1'($urandom); id_src2_vld = 1'($urandom);
        ex_wb_en = 1'($urandom); ex_mem_r_en = 1'($urandom); mem_wb_en = 1'($urandom);
        fwd_en = 1'($urandom);
        ex_branch_taken = ($urandom_range(0, 3) == 0);
        mem_access = ($urandom_range(0, 2) == 0);
    endtask

    // Called shortly after a rising edge: checks this cycle at the falling edge, then advances the model.
    task automatic cycle();
        int         ph;
        bit         fz, hz, busy;
        logic [6:0] exp;
        @(negedge clk);
        ph = m_phase;
        if (ph < 0 && mem_access) ph = 0;
        fz   = mem_access && ph >= 0 && ph < W;
        hz   = model_hazard();
        busy = ph >= 1 && ph <= W - 1;
        if (fz)                   exp = 7'b0000000;
        else if (ex_branch_taken) exp = 7'b1111111;
        else if (hz)              exp = 7'b0011101;
        else                      exp = 7'b1111100;
        last_ctrl = w_ctrl;
        chk("ctrl", 32'(w_ctrl), 32'(exp));
        chk("sram_busy", 32'(sram_busy), 32'(busy));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        @(posedge clk);
        if ((fz || hz) && m_stall != 16'hFFFF) m_stall++;
        if (ph >= 0) m_phase = (ph == W) ? -1 : ph + 1;
        #1;
    endtask

    initial begin
        int cnt;
        clr_in();
        rst_n = 1'b0;
        #3;
        chk("rst_busy", 32'(sram_busy), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single access from cycle 0: four frozen cycles, then DONE.
        mem_access = 1'b1;
        for (int i = 0; i < W + 1; i++) cycle();
        chk("acc_stall4", 32'(stall_cnt), 4);
        mem_access = 1'b0;
        cycle();

        // RAW on EX destination without forwarding, then with forwarding and no load.
        id_src1 = 3; id_src1_vld = 1; ex_dest = 3; ex_wb_en = 1;
        #2;
        chk("raw_nofwd", 32'(w_ctrl), 32'(7'b0011101));
        cycle();
        fwd_en = 1; ex_mem_r_en = 0;
        #2;
        chk("raw_fwd", 32'(w_ctrl), 32'(7'b1111100));
        cycle();

        // Load-use hazard coinciding with a taken branch.
        clr_in();
        fwd_en = 1; ex_mem_r_en = 1; ex_wb_en = 1; ex_dest = 5; id_src2 = 5; id_src2_vld = 1;
        ex_branch_taken = 1;
        #2;
        chk("br_wins", 32'(w_ctrl), 32'(7'b1111111));
        cycle();

        // Back-to-back memory instructions under branch+hazard: two DONE cycles in ten.
        mem_access = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * (W + 1); i++) begin
            cycle();
            if (last_ctrl == 7'b1111111) cnt++;
        end
        chk("b2b_done", 32'(cnt), 2);

        clr_in();
        for (int i = 0; i < W + 1; i++) cycle();
        for (int i = 0; i < 400; i++) begin
            rand_in();
            cycle();
        end

        // Async reset in WAIT with wcnt==1.
        clr_in();
        for (int i = 0; i < W + 1; i++) cycle();
        mem_access = 1'b1;
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(sram_busy), 0);
        chk("arst_stall", 32'(stall_cnt), 0);
        chk("arst_frz", 32'(w_ctrl), 32'(7'b0000000));
        m_phase = -1;
        m_stall = 0;
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) cycle();

        // Saturation of the stall counter.
        clr_in();
        id_src1 = 1; id_src1_vld = 1; ex_dest = 1; ex_wb_en = 1;
        for (int i = 0; i < 65536; i++) cycle();
        chk("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
